// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and rise-to-rise period of an
// asynchronous PWM input and flags a stuck (edge-free) input.
//
// Parameters
//   SYNC_STAGES  synchronizer depth for PwmIn (2..3)
//   TIMEOUT      edge-free cycles before the input is declared stuck (256..1023)
//
// Ports
//   SysClk      in   system clock, rising-edge active
//   Reset       in   asynchronous, active-high reset
//   PwmIn       in   raw PWM input, asynchronous to SysClk
//   DutyCycle   out  last high time in SysClk cycles, saturated at 255
//   Period      out  last rise-to-rise period in SysClk cycles, saturated at 1023
//   Valid       out  one-cycle pulse marking new DutyCycle/Period
//   Stuck       out  PwmIn has shown no edge for TIMEOUT cycles
//   StuckLevel  out  synchronized PwmIn level captured when Stuck asserted
module pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 512
) (
  input  logic       SysClk,
  input  logic       Reset,
  input  logic       PwmIn,
  output logic [7:0] DutyCycle,
  output logic [9:0] Period,
  output logic       Valid,
  output logic       Stuck,
  output logic       StuckLevel
);

  typedef enum logic [1:0] {
    SEEK,
    HIGH,
    LOW
  } stateT;

  localparam logic [9:0] IdleMax  = 10'(TIMEOUT);
  localparam logic [9:0] IdleTrip = 10'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] syncFf;
  logic                   s;
  logic                   sD;
  logic                   rise;
  logic                   fall;
  logic                   anyEdge;
  logic                   timeoutHit;
  stateT                  state;
  logic [7:0]             highCnt;
  logic [9:0]             perCnt;
  logic [9:0]             idleCnt;

  assign s          = syncFf[SYNC_STAGES-1];
  assign rise       = s & ~sD;
  assign fall       = ~s & sD;
  assign anyEdge    = rise | fall;
  // Fires only on the transition into saturation, so a stuck input
  // produces exactly one Valid pulse; an edge always wins.
  assign timeoutHit = ~anyEdge & (idleCnt == IdleTrip);

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      syncFf     <= '0;
      sD         <= 1'b0;
      state      <= SEEK;
      highCnt    <= '0;
      perCnt     <= '0;
      idleCnt    <= '0;
      DutyCycle  <= '0;
      Period     <= '0;
      Valid      <= 1'b0;
      Stuck      <= 1'b0;
      StuckLevel <= 1'b0;
    end else begin
      syncFf <= {syncFf[SYNC_STAGES-2:0], PwmIn};
      sD     <= s;
      Valid  <= 1'b0;

      if (anyEdge) begin
        idleCnt <= '0;
        Stuck   <= 1'b0;
      end else if (idleCnt != IdleMax) begin
        idleCnt <= idleCnt + 10'd1;
      end

      if (timeoutHit) begin
        Stuck      <= 1'b1;
        StuckLevel <= s;
        DutyCycle  <= s ? 8'hFF : 8'h00;
        Period     <= '0;
        Valid      <= 1'b1;
        state      <= SEEK;
      end else begin
        case (state)
          SEEK: begin
            if (rise) begin
              state   <= HIGH;
              highCnt <= 8'd1;
              perCnt  <= 10'd1;
            end
          end
          HIGH: begin
            if (fall) begin
              state <= LOW;
            end else if (highCnt != 8'hFF) begin
              highCnt <= highCnt + 8'd1;
            end
            if (perCnt != 10'h3FF) begin
              perCnt <= perCnt + 10'd1;
            end
          end
          LOW: begin
            if (rise) begin
              DutyCycle <= highCnt;
              Period    <= perCnt;
              Valid     <= 1'b1;
              highCnt   <= 8'd1;
              perCnt    <= 10'd1;
              state     <= HIGH;
            end else if (perCnt != 10'h3FF) begin
              perCnt <= perCnt + 10'd1;
            end
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops, legal range 2..3.
REQ-002 Parameter TIMEOUT, default 512: consecutive edge-free cycles after which the input is declared stuck, legal range 256..1023.
REQ-003 SysClk  in  1  system clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 PwmIn  in  1  raw PWM input, asynchronous to SysClk.
REQ-006 DutyCycle  out  8  last measured high time in SysClk cycles, saturated at 255.
REQ-007 Period  out  10  last measured rise-to-rise period in SysClk cycles, saturated at 1023.
REQ-008 Valid  out  1  one-cycle pulse marking new DutyCycle/Period values.
REQ-009 Stuck  out  1  level; PwmIn has shown no edge for TIMEOUT cycles.
REQ-010 StuckLevel  out  1  synchronized PwmIn level captured when Stuck asserted.

Function
REQ-011 PwmIn shall pass through SYNC_STAGES flops; the last stage is s, and s_d is s delayed one cycle.
REQ-012 rise = s AND NOT s_d; fall = NOT s AND s_d; exactly one of rise or fall, or neither, in any cycle.
REQ-013 The FSM shall have three states: SEEK, HIGH, LOW.
REQ-014 SEEK: on rise go to HIGH, set HighCnt=1 and PerCnt=1, and assert no Valid; otherwise hold.
REQ-015 HIGH: on fall go to LOW, HighCnt unchanged, PerCnt+1; otherwise HighCnt+1 (saturating at 255) and PerCnt+1 (saturating at 1023).
REQ-016 LOW: on rise, register DutyCycle<=HighCnt, Period<=PerCnt, pulse Valid, set HighCnt=1 and PerCnt=1, and go to HIGH; otherwise PerCnt+1 (saturating).
REQ-017 Result: input high H cycles and low L cycles gives DutyCycle=min(H,255) and Period=min(H+L,1023).
REQ-018 The first rise after reset or after a stuck condition only arms the FSM; the first Valid requires two rises.
REQ-019 Latency: with SYNC_STAGES=2, Valid is high after the 3rd rising SysClk edge counted from the first edge that samples PwmIn high (SYNC_STAGES+1 edges in general).
REQ-020 IdleCnt shall clear on any rise or fall, otherwise increment, saturating at TIMEOUT.
REQ-021 On the edge where IdleCnt reaches TIMEOUT: Stuck<=1, StuckLevel<=s, DutyCycle<=(s?255:0), Period<=0, one Valid pulse, and FSM goes to SEEK.
REQ-022 While Stuck=1, no further Valid pulses shall be generated until an edge occurs.
REQ-023 The first edge after Stuck shall clear Stuck (StuckLevel holds its value) and is handled as a SEEK-state rise or ignored fall.
REQ-024 Edge detection has priority over timeout; the two cannot both act in the same cycle.
REQ-025 DutyCycle, Period and StuckLevel shall hold their values between updates; Valid is registered, glitch-free, and exactly one cycle wide.

Reset
REQ-026 Reset=1 shall immediately force: sync flops=0, s_d=0, FSM=SEEK, HighCnt=PerCnt=IdleCnt=0, DutyCycle=0, Period=0, Valid=0, Stuck=0, StuckLevel=0.
REQ-027 Reset asserted mid-measurement shall discard the partial measurement with no Valid pulse.
REQ-028 PwmIn already high at reset release shall produce a rise that only arms the FSM (no Valid).

Verification
REQ-029 Repeating 64 high/192 low -> from the second rise on, one Valid per period with DutyCycle=64 and Period=256, Stuck=0.
REQ-030 Repeating 300 high/100 low -> DutyCycle=255, Period=400.
REQ-031 PwmIn held 0 from reset release -> after exactly 512 cycles Stuck=1, StuckLevel=0, DutyCycle=0, Period=0, a single Valid, and no further Valid for the next 2000 cycles.
REQ-032 PwmIn held 1 after a valid 128/128 stream -> 512 cycles after the last rise, Stuck=1, StuckLevel=1, DutyCycle=255; then toggling 128/128 resumes -> Stuck=0 on the first edge, Valid with DutyCycle=128 and Period=256 after two rises.
REQ-033 Reset pulsed 30 cycles into a high phase -> all outputs 0 immediately, and no Valid until two rises after release.
REQ-034 Single rise on PwmIn (SYNC_STAGES=2) following an armed LOW state -> Valid observed exactly 3 SysClk edges after the first sampling edge.
